// File: rtl/fft_pkg.sv
// Shared FFT datapath constants and encodings for the twiddle multiplier.
// SEQ_MULT_BOOTH4_EN selects the radix-4 Booth iteration count.
package fft_pkg;

    localparam int MULT_A_W   = 8;
    localparam int MULT_B_W   = 9;
    localparam int MULT_P_W   = 17;
    localparam int MULT_CNT_W = 4;

    typedef enum logic {
        MULT_IDLE = 1'b0,
        MULT_CALC = 1'b1
    } mult_state_t;

    typedef enum logic [2:0] {
        BOOTH_ZERO = 3'd0,
        BOOTH_POS1 = 3'd1,
        BOOTH_POS2 = 3'd2,
        BOOTH_NEG1 = 3'd3,
        BOOTH_NEG2 = 3'd4
    } booth_sel_t;

`ifdef SEQ_MULT_BOOTH4_EN
    localparam int MULT_ITERS = 5;
`else
    localparam int MULT_ITERS = 9;
`endif

    localparam logic [MULT_CNT_W-1:0] MULT_LAST_ITER = MULT_CNT_W'(MULT_ITERS - 1);

endpackage

// File: rtl/N_bit_adder.sv
// Generic N-bit modulo-2^N adder used for the multiplier accumulator.
module N_bit_adder #(
    parameter int N = 17
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/booth4_recode.sv
// Radix-4 Booth recoder: maps {b[2i+1], b[2i], b[2i-1]} to a {0, +-1, +-2} digit select.
module booth4_recode
    import fft_pkg::*;
(
    input  logic [2:0]  bits,
    output booth_sel_t  sel
);

    always_comb begin
        sel = BOOTH_ZERO;
        case (bits)
            3'b001, 3'b010: sel = BOOTH_POS1;
            3'b011:         sel = BOOTH_POS2;
            3'b100:         sel = BOOTH_NEG2;
            3'b101, 3'b110: sel = BOOTH_NEG1;
            default:        sel = BOOTH_ZERO;
        endcase
    end

endmodule

// File: rtl/pos_2_neg.sv
// Two's-complement negation: neg_val = -in_val modulo 2^N.
module pos_2_neg #(
    parameter int N = 17
) (
    input  logic [N-1:0] in_val,
    output logic [N-1:0] neg_val
);

    assign neg_val = ~in_val + 1'b1;

endmodule

// File: rtl/seq_mult_s8x9.sv
// Sequential 8x9 signed multiplier with start/data_valid handshake, one multiplier bit per cycle.
// Define SEQ_MULT_BOOTH4_EN for a radix-4 Booth datapath (5 iterations instead of 9).
module seq_mult_s8x9
    import fft_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [MULT_A_W-1:0] input_0,
    input  logic [MULT_B_W-1:0] input_1,
    output logic [MULT_P_W-1:0] out,
    output logic                data_valid
);

    mult_state_t state;
    mult_state_t next_state;

    logic [MULT_CNT_W-1:0] cnt;
    logic [MULT_P_W-1:0]   mcand;
    logic [MULT_P_W-1:0]   neg_mcand;
    logic [MULT_P_W-1:0]   acc;
    logic [MULT_P_W-1:0]   addend;
    logic [MULT_P_W-1:0]   sum;
    logic [MULT_B_W-1:0]   mplier;
    logic                  accept;
    logic                  finish;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= MULT_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Completion drops straight back to IDLE so a start in the data_valid cycle is accepted.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            MULT_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = MULT_CALC;
                end
            end
            MULT_CALC: begin
                if (cnt == MULT_LAST_ITER) begin
                    finish     = 1'b1;
                    next_state = MULT_IDLE;
                end
            end
            default: next_state = MULT_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            out        <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= finish;
            if (accept) begin
                mcand  <= {{(MULT_P_W-MULT_A_W){input_0[MULT_A_W-1]}}, input_0};
                mplier <= input_1;
                acc    <= '0;
                cnt    <= '0;
            end else if (state == MULT_CALC) begin
                if (finish) begin
                    out <= sum;
                end else begin
                    acc <= sum;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    pos_2_neg #(.N(MULT_P_W)) u_neg (
        .in_val  (mcand),
        .neg_val (neg_mcand)
    );

    N_bit_adder #(.N(MULT_P_W)) u_add (
        .a   (acc),
        .b   (addend),
        .sum (sum)
    );

`ifdef SEQ_MULT_BOOTH4_EN
    logic [MULT_B_W+1:0] ext_b;
    logic [3:0]          shamt;
    logic [2:0]          triplet;
    booth_sel_t          sel;

    // Multiplier sign-extended to 10 bits with the implicit b[-1] = 0 appended below bit 0.
    assign ext_b   = {mplier[MULT_B_W-1], mplier, 1'b0};
    assign shamt   = {cnt[2:0], 1'b0};
    assign triplet = ext_b[shamt +: 3];

    booth4_recode u_recode (
        .bits (triplet),
        .sel  (sel)
    );

    always_comb begin
        addend = '0;
        case (sel)
            BOOTH_POS1: addend = mcand << shamt;
            BOOTH_POS2: addend = mcand << (shamt + 4'd1);
            BOOTH_NEG1: addend = neg_mcand << shamt;
            BOOTH_NEG2: addend = neg_mcand << (shamt + 4'd1);
            default:    addend = '0;
        endcase
    end
`else
    // The sign bit carries weight -2^8, so the last iteration subtracts instead of adds.
    always_comb begin
        addend = '0;
        if (mplier[cnt]) begin
            if (cnt == MULT_LAST_ITER) begin
                addend = neg_mcand << cnt;
            end else begin
                addend = mcand << cnt;
            end
        end
    end
`endif

endmodule
